// File: rtl/lc3_trap_sequencer.sv
// LC-3 TRAP microsequencer: accepts a zero-extended trap vector, reads the
// vector table entry, then commits the return PC to R7 and redirects fetch.
// The pipeline is stalled (BUSY) from the first FETCH cycle through COMMIT.
module lc3_trap_sequencer #(
  parameter int          TIMEOUT = 255,
  parameter logic [15:0] ERR_PC  = 16'h0200,
  parameter int          CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             TRAP_VALID,
  output logic             TRAP_ACK,
  input  logic [15:0]      VEC_ADDR,
  input  logic [15:0]      RET_PC,
  input  logic             FLUSH,
  output logic             MEM_REQ,
  output logic [15:0]      MEM_ADDR,
  input  logic             MEM_RDY,
  input  logic [15:0]      MEM_DATA,
  output logic             R7_WE,
  output logic [15:0]      R7_DATA,
  output logic             PC_LD,
  output logic [15:0]      PC_OUT,
  output logic             BUSY,
  output logic             TRAP_ERR,
  output logic [CNT_W-1:0] TRAP_CNT
);

  // Timer only has to reach TIMEOUT, so size it to that.
  localparam int          TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [15:0]      ret_q, ret_d;
  logic             mem_req_q, mem_req_d;
  logic [15:0]      mem_addr_q, mem_addr_d;   // doubles as the latched vector
  logic             r7_we_q, r7_we_d;
  logic [15:0]      r7_data_q, r7_data_d;
  logic             pc_ld_q, pc_ld_d;
  logic [15:0]      pc_out_q, pc_out_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic commit_go;

  assign accept = (state_q == IDLE) && TRAP_VALID && !FLUSH;

  // Next-state and registered-output computation; every path starts from hold.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ret_d      = ret_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    r7_we_d    = 1'b0;
    r7_data_d  = r7_data_q;
    pc_ld_d    = 1'b0;
    pc_out_d   = pc_out_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    commit_go  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = FETCH;
          timer_d    = '0;
          ret_d      = RET_PC;
          mem_req_d  = 1'b1;
          mem_addr_d = {8'h00, VEC_ADDR[7:0]};
          // A fresh accept clears the sticky flag unless the vector is bad.
          err_d      = (VEC_ADDR[15:8] != 8'h00);
        end
      end

      FETCH: begin
        timer_d = timer_q + 1'b1;
        if (FLUSH) begin
          // Squash outranks read data: abandon without side effects.
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (MEM_RDY) begin
          // Data wins over a same-cycle timeout.
          commit_go = 1'b1;
          pc_out_d  = MEM_DATA;
        end else if (timer_q == TMO) begin
          commit_go = 1'b1;
          pc_out_d  = ERR_PC;
          err_d     = 1'b1;
        end
        if (commit_go) begin
          state_d   = COMMIT;
          mem_req_d = 1'b0;
          r7_we_d   = 1'b1;
          r7_data_d = ret_q;
          pc_ld_d   = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end

      COMMIT: begin
        // Architecturally committed: FLUSH has no effect here.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ret_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      r7_we_q    <= 1'b0;
      r7_data_q  <= '0;
      pc_ld_q    <= 1'b0;
      pc_out_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ret_q      <= ret_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      r7_we_q    <= r7_we_d;
      r7_data_q  <= r7_data_d;
      pc_ld_q    <= pc_ld_d;
      pc_out_q   <= pc_out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign TRAP_ACK = (state_q == IDLE);
  assign BUSY     = (state_q != IDLE);
  assign MEM_REQ  = mem_req_q;
  assign MEM_ADDR = mem_addr_q;
  assign R7_WE    = r7_we_q;
  assign R7_DATA  = r7_data_q;
  assign PC_LD    = pc_ld_q;
  assign PC_OUT   = pc_out_q;
  assign TRAP_ERR = err_q;
  assign TRAP_CNT = cnt_q;

endmodule

// File: tb/tb_lc3_trap_sequencer.sv
// Directed bench for lc3_trap_sequencer. Two instances share one stimulus:
// "a" with default parameters, "b" with TIMEOUT=4 and CNT_W=2 for the
// timeout and counter-wrap cases.
module tb_lc3_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_valid;
  logic [15:0] vec_addr;
  logic [15:0] ret_pc;
  logic        flush;
  logic        mem_rdy;
  logic [15:0] mem_data;

  logic        a_ack, a_req, a_r7_we, a_pc_ld, a_busy, a_err;
  logic [15:0] a_addr, a_r7_data, a_pc_out;
  logic [7:0]  a_cnt;
  logic        b_ack, b_req, b_r7_we, b_pc_ld, b_busy, b_err;
  logic [15:0] b_addr, b_r7_data, b_pc_out;
  logic [1:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lc3_trap_sequencer u_a (
    .CLK(clk), .RST_N(rst_n), .TRAP_VALID(trap_valid), .TRAP_ACK(a_ack),
    .VEC_ADDR(vec_addr), .RET_PC(ret_pc), .FLUSH(flush),
    .MEM_REQ(a_req), .MEM_ADDR(a_addr), .MEM_RDY(mem_rdy), .MEM_DATA(mem_data),
    .R7_WE(a_r7_we), .R7_DATA(a_r7_data), .PC_LD(a_pc_ld), .PC_OUT(a_pc_out),
    .BUSY(a_busy), .TRAP_ERR(a_err), .TRAP_CNT(a_cnt)
  );

  lc3_trap_sequencer #(.TIMEOUT(4), .ERR_PC(16'h0200), .CNT_W(2)) u_b (
    .CLK(clk), .RST_N(rst_n), .TRAP_VALID(trap_valid), .TRAP_ACK(b_ack),
    .VEC_ADDR(vec_addr), .RET_PC(ret_pc), .FLUSH(flush),
    .MEM_REQ(b_req), .MEM_ADDR(b_addr), .MEM_RDY(mem_rdy), .MEM_DATA(mem_data),
    .R7_WE(b_r7_we), .R7_DATA(b_r7_data), .PC_LD(b_pc_ld), .PC_OUT(b_pc_out),
    .BUSY(b_busy), .TRAP_ERR(b_err), .TRAP_CNT(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_trap(input logic [15:0] v, input logic [15:0] r);
    trap_valid = 1'b1;
    vec_addr   = v;
    ret_pc     = r;
    step();
    trap_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; trap_valid = 1'b0; vec_addr = '0; ret_pc = '0;
    flush = 1'b0; mem_rdy = 1'b0; mem_data = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_ack",    a_ack, 1);
    chk("rst_busy",   a_busy, 0);
    chk("rst_req",    a_req, 0);
    chk("rst_addr",   a_addr, 16'h0000);
    chk("rst_pcout",  a_pc_out, 16'h0000);
    chk("rst_err",    a_err, 0);
    chk("rst_cnt",    a_cnt, 0);

    // Zero-wait trap: accept, FETCH with MEM_RDY, COMMIT, IDLE
    start_trap(16'h0025, 16'h3001);
    chk("zw_busy_f",  a_busy, 1);
    chk("zw_ack_f",   a_ack, 0);
    chk("zw_req",     a_req, 1);
    chk("zw_addr",    a_addr, 16'h0025);
    chk("zw_r7we_f",  a_r7_we, 0);
    mem_rdy = 1'b1; mem_data = 16'h04A0;
    step();
    mem_rdy = 1'b0;
    chk("zw_busy_c",  a_busy, 1);
    chk("zw_r7we",    a_r7_we, 1);
    chk("zw_r7data",  a_r7_data, 16'h3001);
    chk("zw_pcld",    a_pc_ld, 1);
    chk("zw_pcout",   a_pc_out, 16'h04A0);
    chk("zw_req_c",   a_req, 0);
    step();
    chk("zw_busy_i",  a_busy, 0);
    chk("zw_r7we_i",  a_r7_we, 0);
    chk("zw_pcld_i",  a_pc_ld, 0);
    chk("zw_pchold",  a_pc_out, 16'h04A0);
    chk("zw_cnt",     a_cnt, 1);
    chk("zw_cnt_b",   b_cnt, 1);

    // Wait states: MEM_RDY in the 6th FETCH cycle (instance b times out meanwhile)
    start_trap(16'h0030, 16'h3100);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ws_req%0d", i), a_req, 1);
      chk($sformatf("ws_addr%0d", i), a_addr, 16'h0030);
      chk($sformatf("ws_we%0d", i), a_r7_we, 0);
      if (i < 5) step();
    end
    mem_rdy = 1'b1; mem_data = 16'h0555;
    step();
    mem_rdy = 1'b0;
    chk("ws_r7we",    a_r7_we, 1);
    chk("ws_pcout",   a_pc_out, 16'h0555);
    chk("ws_r7data",  a_r7_data, 16'h3100);
    chk("ws_err",     a_err, 0);
    step();
    chk("ws_r7we_i",  a_r7_we, 0);
    chk("ws_pcld_i",  a_pc_ld, 0);
    chk("ws_cnt",     a_cnt, 2);
    chk("ws_b_err",   b_err, 1);
    chk("ws_b_pc",    b_pc_out, 16'h0200);
    chk("ws_b_cnt",   b_cnt, 2);

    // Timeout on b: 5 FETCH cycles then COMMIT to ERR_PC
    start_trap(16'h0040, 16'h3200);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("to_req%0d", i), b_req, 1);
      chk($sformatf("to_pcld%0d", i), b_pc_ld, 0);
      step();
    end
    chk("to_pcld",    b_pc_ld, 1);
    chk("to_r7we",    b_r7_we, 1);
    chk("to_pcout",   b_pc_out, 16'h0200);
    chk("to_r7data",  b_r7_data, 16'h3200);
    chk("to_err",     b_err, 1);
    step();
    chk("to_busy_i",  b_busy, 0);
    chk("to_cnt",     b_cnt, 3);
    chk("to_a_busy",  a_busy, 1);
    // Flush the still-fetching default instance
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("to_a_flush", a_busy, 0);
    chk("to_a_cnt",   a_cnt, 2);
    // Clean trap clears the sticky error; b's counter wraps 3 -> 0
    start_trap(16'h0041, 16'h3300);
    chk("cl_err_clr", b_err, 0);
    mem_rdy = 1'b1; mem_data = 16'h0600;
    step();
    mem_rdy = 1'b0;
    chk("cl_pcout",   b_pc_out, 16'h0600);
    step();
    chk("cl_b_wrap",  b_cnt, 0);
    chk("cl_a_cnt",   a_cnt, 3);
    chk("cl_err_i",   b_err, 0);

    // Flush in 2nd FETCH cycle with simultaneous MEM_RDY
    start_trap(16'h0050, 16'h3400);
    step();
    chk("fl_busy2",   a_busy, 1);
    flush = 1'b1; mem_rdy = 1'b1; mem_data = 16'h0777;
    step();
    flush = 1'b0; mem_rdy = 1'b0;
    chk("fl_busy",    a_busy, 0);
    chk("fl_req",     a_req, 0);
    chk("fl_r7we",    a_r7_we, 0);
    chk("fl_pcld",    a_pc_ld, 0);
    step();
    chk("fl_r7we2",   a_r7_we, 0);
    chk("fl_pchold",  a_pc_out, 16'h0600);
    chk("fl_cnt",     a_cnt, 3);

    // Flush during COMMIT is ignored
    start_trap(16'h0060, 16'h3500);
    mem_rdy = 1'b1; mem_data = 16'h0888;
    step();
    mem_rdy = 1'b0;
    flush = 1'b1;
    chk("fc_pcld",    a_pc_ld, 1);
    step();
    chk("fc_cnt",     a_cnt, 4);
    chk("fc_pcout",   a_pc_out, 16'h0888);
    chk("fc_busy",    a_busy, 0);
    // Flush coinciding with TRAP_VALID in IDLE: no accept
    trap_valid = 1'b1; vec_addr = 16'h0070;
    step();
    trap_valid = 1'b0; flush = 1'b0;
    chk("fa_busy",    a_busy, 0);
    chk("fa_req",     a_req, 0);
    step();
    chk("fa_busy2",   a_busy, 0);

    // Bad vector: upper byte masked, error flagged
    start_trap(16'h1021, 16'h3600);
    chk("bv_addr",    a_addr, 16'h0021);
    chk("bv_err",     a_err, 1);
    chk("bv_busy",    a_busy, 1);
    // Async reset mid-FETCH clears outputs without waiting for a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy",    a_busy, 0);
    chk("ar_req",     a_req, 0);
    chk("ar_addr",    a_addr, 16'h0000);
    chk("ar_err",     a_err, 0);
    chk("ar_cnt",     a_cnt, 0);
    chk("ar_pcout",   a_pc_out, 16'h0000);
    chk("ar_r7data",  a_r7_data, 16'h0000);
    chk("ar_b_cnt",   b_cnt, 0);
    #1 rst_n = 1'b1;
    step();
    chk("ar_r7we",    a_r7_we, 0);
    chk("ar_ack",     a_ack, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_trap_sequencer.md
Name: lc3_trap_sequencer

Overview:
- Consumes the zero-extended trap vector from the zero-extension stage and executes the TRAP microsequence for the pipelined LC-3.
- Reads the trap vector table entry at x0000–x00FF, writes the return PC to R7, and redirects fetch to the service routine.
- Stalls the pipeline while the sequence is in flight.
- Sits between decode/zero-extend and the memory / register-file / PC-mux paths.

Parameters:
- TIMEOUT, 255: maximum FETCH cycles without MEM_RDY before aborting to ERR_PC.
- ERR_PC, 16'h0200: PC loaded when the vector read times out.
- CNT_W, 8: width of the committed-trap counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TRAP_VALID  in  1  decode presents a TRAP instruction.
- TRAP_ACK  out  1  sequencer can accept (high only in IDLE).
- VEC_ADDR  in  16  zero-extended trapvect8 from the zero-extension stage.
- RET_PC  in  16  incremented PC of the TRAP instruction.
- FLUSH  in  1  pipeline flush/squash.
- MEM_REQ  out  1  vector-table read request.
- MEM_ADDR  out  16  vector-table read address.
- MEM_RDY  in  1  read data valid this cycle.
- MEM_DATA  in  16  read data.
- R7_WE  out  1  one-cycle write enable for R7.
- R7_DATA  out  16  return address to R7.
- PC_LD  out  1  one-cycle PC redirect strobe.
- PC_OUT  out  16  redirect target.
- BUSY  out  1  stall request to the pipeline.
- TRAP_ERR  out  1  sticky error flag.
- TRAP_CNT  out  CNT_W  count of committed traps.

Behaviour:
- **Reset (RST_N low, async):**
  - state=IDLE.
  - MEM_REQ=0, MEM_ADDR=0, R7_WE=0, R7_DATA=0, PC_LD=0, PC_OUT=0, TRAP_ERR=0, TRAP_CNT=0.
  - Timer=0; internal vec/ret latches cleared.
  - Reset mid-sequence abandons it with no R7/PC side effects.
- **Combinational outputs:**
  - TRAP_ACK = (state==IDLE).
  - BUSY = (state!=IDLE).
- **Accept:** TRAP_VALID & TRAP_ACK & ~FLUSH, in cycle N.
  - Latch vec = {8'h00, VEC_ADDR[7:0]} and ret = RET_PC.
  - If VEC_ADDR[15:8] != 0, set TRAP_ERR and proceed with the masked address.
  - A new accept clears TRAP_ERR unless this accept sets it.
  - Go to FETCH.
- **FETCH:**
  - MEM_REQ=1 and MEM_ADDR=vec, held stable until the request ends.
  - Timer increments each FETCH cycle, starting at 0.
  - MEM_RDY=1: capture MEM_DATA as target; go to COMMIT.
  - Timer==TIMEOUT without MEM_RDY: target=ERR_PC, set TRAP_ERR, go to COMMIT.
  - MEM_RDY and the timeout in the same cycle: data wins, no error.
  - FLUSH=1: return to IDLE with no commit and no counter increment; MEM_REQ low next cycle.
  - FLUSH beats MEM_RDY in the same cycle.
- **COMMIT:** exactly one cycle.
  - R7_WE=1, R7_DATA=ret, PC_LD=1, PC_OUT=target.
  - TRAP_CNT += 1, wrapping modulo 2^CNT_W.
  - FLUSH is ignored (the trap is architecturally committed).
  - Next state is IDLE.
- **Outside COMMIT:** R7_WE and PC_LD are 0. R7_DATA and PC_OUT hold their last values.
- **Latency:**
  - Minimum 3 cycles, accept to IDLE: accept at N, FETCH at N+1 with MEM_RDY, COMMIT at N+2, IDLE at N+3.
  - Back-to-back accept is possible at N+3.
- **TRAP_VALID while BUSY:** not accepted. Decode must hold the instruction, which it does via BUSY.
- **Register outputs:** all registered except TRAP_ACK and BUSY. There is no combinational path from MEM_DATA to any output.

Test Plan:
- **Zero-wait trap:** reset, then TRAP_VALID with VEC_ADDR=x0025, RET_PC=x3001; MEM_RDY in the first FETCH cycle with MEM_DATA=x04A0.
  - MEM_ADDR=x0025.
  - In the COMMIT cycle, R7_WE=1 with R7_DATA=x3001, and PC_LD=1 with PC_OUT=x04A0.
  - TRAP_CNT=1; BUSY high for exactly 2 cycles.
- **Wait states:** MEM_RDY delayed 5 cycles.
  - MEM_REQ/MEM_ADDR stable for 6 cycles; single COMMIT pulse; no TRAP_ERR.
- **Timeout:** TIMEOUT=4, MEM_RDY never asserted.
  - COMMIT after 5 FETCH cycles with PC_OUT=x0200 and TRAP_ERR=1.
  - The next clean trap clears TRAP_ERR.
- **Flush in FETCH:** FLUSH pulsed in the 2nd FETCH cycle.
  - Returns to IDLE; no R7_WE/PC_LD; TRAP_CNT unchanged.
  - A simultaneous MEM_RDY is ignored.
- **Flush in COMMIT / flush at accept:**
  - FLUSH during COMMIT: commit still occurs.
  - FLUSH coinciding with TRAP_VALID in IDLE: no accept, BUSY stays low.
- **Bad vector and counter wrap:**
  - VEC_ADDR=x1021 gives MEM_ADDR=x0021 and TRAP_ERR=1.
  - With CNT_W=2, four traps return TRAP_CNT to 0.
  - Async reset mid-FETCH clears all outputs immediately.
